// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding and default width.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when the bit underflows.
// Latency: purely combinational.
// Backpressure: none.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow generation/propagation.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (a - b - borrow_in) mod 2^WIDTH, LSB first.
// Latency: WIDTH+1 cycles from the accepting start edge to the done pulse.
// Backpressure: start is accepted only in IDLE or DONE; requests during SHIFT are dropped.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             br;
  // Holds the WIDTH-1 most recently produced bits; the final bit is merged
  // straight into diff on the completion edge.
  logic [WIDTH-2:0] part;
  logic [CW-1:0]    cnt;

  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH-1:0] part_next;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    part_next = {fs_d, part};
  end

  // Sequencer, operand shifting, borrow flop and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      br         <= 1'b0;
      part       <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= borrow_in;
            part  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= fs_bout;
          part <= part_next[WIDTH-1:1];
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            diff       <= part_next;
            borrow_out <= fs_bout;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4).
// Latency expectation: done exactly 5 cycles after the accepting edge.
// Backpressure expectation: start during SHIFT is dropped.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       borrow_in;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       borrow_out;

  int checks;
  int errors;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-cycle start at a negedge (cycle 0), then wait for done.
  // cyc returns the cycle number in which done was seen, or 0 on timeout.
  task automatic issue_and_wait(input logic [3:0] av, input logic [3:0] bv,
                                input logic binv, output int cyc);
    cyc = 0;
    a = av; b = bv; borrow_in = binv; start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (diff !== 4'd0) begin errors++; $display("FAIL reset_diff got=%0d exp=0", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow got=%b exp=0", borrow_out); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // 6-3-0: busy for cycles 1..4, done with diff=3 in cycle 5.
  task automatic test_basic();
    logic [4:0] busy_seen;
    logic [4:0] done_seen;
    a = 4'd6; b = 4'd3; borrow_in = 1'b0; start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      busy_seen[i-1] = busy;
      done_seen[i-1] = done;
    end
    checks++; if (busy_seen !== 5'b01111) begin errors++; $display("FAIL basic_busy_pattern got=%b exp=01111", busy_seen); end
    checks++; if (done_seen !== 5'b10000) begin errors++; $display("FAIL basic_done_pattern got=%b exp=10000", done_seen); end
    checks++; if (diff !== 4'd3) begin errors++; $display("FAIL basic_diff got=%0d exp=3", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL basic_borrow got=%b exp=0", borrow_out); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_single got=%b exp=0", done); end
  endtask

  // Borrow cases with hand-computed expectations.
  task automatic test_borrow();
    logic [3:0] va   [3] = '{4'd3, 4'd0, 4'd15};
    logic [3:0] vb   [3] = '{4'd6, 4'd0, 4'd15};
    logic       vbin [3] = '{1'b0, 1'b1, 1'b1};
    logic [3:0] ed   [3] = '{4'd13, 4'd15, 4'd15};
    logic       ebo  [3] = '{1'b1, 1'b1, 1'b1};
    int cyc;
    for (int k = 0; k < 3; k++) begin
      issue_and_wait(va[k], vb[k], vbin[k], cyc);
      checks++; if (cyc != 5) begin errors++; $display("FAIL borrow_latency[%0d] got=%0d exp=5", k, cyc); end
      checks++; if (diff !== ed[k]) begin errors++; $display("FAIL borrow_diff[%0d] got=%0d exp=%0d", k, diff, ed[k]); end
      checks++; if (borrow_out !== ebo[k]) begin errors++; $display("FAIL borrow_bout[%0d] got=%b exp=%b", k, borrow_out, ebo[k]); end
      @(negedge clk);
    end
  endtask

  // All 512 combinations, start held high; operands swapped right after each accept.
  task automatic test_back_to_back();
    int stray;
    int pulses;
    int ea, eb, ebin, ed, ebo;
    stray = 0; pulses = 0;
    start = 1'b1;
    for (int k = 0; k < 512; k++) begin
      ea = k & 15; eb = (k >> 4) & 15; ebin = (k >> 8) & 1;
      a = 4'(ea); b = 4'(eb); borrow_in = ebin[0];
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        if (done === 1'b1) pulses++;
        if (c < 5 && done !== 1'b0) stray++;
      end
      ed  = (ea - eb - ebin) & 15;
      ebo = (ea < eb + ebin) ? 1 : 0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d] got=%b exp=1", k, done); end
      checks++; if (diff !== 4'(ed)) begin errors++; $display("FAIL b2b_diff[%0d] a=%0d b=%0d bin=%0d got=%0d exp=%0d", k, ea, eb, ebin, diff, ed); end
      checks++; if (borrow_out !== ebo[0]) begin errors++; $display("FAIL b2b_borrow[%0d] got=%b exp=%b", k, borrow_out, ebo[0]); end
    end
    start = 1'b0;
    checks++; if (stray != 0) begin errors++; $display("FAIL b2b_stray_done got=%0d exp=0", stray); end
    checks++; if (pulses != 512) begin errors++; $display("FAIL b2b_pulse_count got=%0d exp=512", pulses); end
    repeat (2) @(negedge clk);
  endtask

  // A second start during SHIFT must be dropped.
  task automatic test_ignore_busy();
    int done_cyc;
    int extra;
    done_cyc = 0; extra = 0;
    a = 4'd7; b = 4'd2; borrow_in = 1'b0; start = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 2) begin
        a = 4'd9; b = 4'd1; start = 1'b1;
      end
      if (done === 1'b1) begin
        if (done_cyc == 0) done_cyc = i;
        else extra++;
      end
      if (i == 5) begin
        checks++; if (diff !== 4'd5) begin errors++; $display("FAIL ignore_diff got=%0d exp=5", diff); end
        checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL ignore_borrow got=%b exp=0", borrow_out); end
      end
    end
    checks++; if (done_cyc != 5) begin errors++; $display("FAIL ignore_latency got=%0d exp=5", done_cyc); end
    checks++; if (extra != 0) begin errors++; $display("FAIL ignore_extra_done got=%0d exp=0", extra); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle_busy got=%b exp=0", busy); end
  endtask

  // Asynchronous reset mid-operation, then a fresh operation.
  task automatic test_reset_mid();
    int cyc;
    int spurious;
    spurious = 0;
    a = 4'd5; b = 4'd1; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (diff !== 4'd0) begin errors++; $display("FAIL rstmid_diff got=%0d exp=0", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL rstmid_borrow got=%b exp=0", borrow_out); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done !== 1'b0) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", spurious); end
    issue_and_wait(4'd8, 4'd8, 1'b0, cyc);
    checks++; if (cyc != 5) begin errors++; $display("FAIL rstmid_latency got=%0d exp=5", cyc); end
    checks++; if (diff !== 4'd0) begin errors++; $display("FAIL rstmid_new_diff got=%0d exp=0", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL rstmid_new_borrow got=%b exp=0", borrow_out); end
    @(negedge clk);
  endtask

  // Results hold while inputs wander with start low.
  task automatic test_hold();
    int cyc;
    issue_and_wait(4'd2, 4'd9, 1'b0, cyc);
    checks++; if (cyc != 5) begin errors++; $display("FAIL hold_latency got=%0d exp=5", cyc); end
    checks++; if (diff !== 4'd9) begin errors++; $display("FAIL hold_diff got=%0d exp=9", diff); end
    checks++; if (borrow_out !== 1'b1) begin errors++; $display("FAIL hold_borrow got=%b exp=1", borrow_out); end
    for (int i = 0; i < 10; i++) begin
      a = 4'($urandom_range(15)); b = 4'($urandom_range(15)); borrow_in = 1'($urandom_range(1));
      @(negedge clk);
      checks++;
      if (diff !== 4'd9 || borrow_out !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle[%0d] got diff=%0d bout=%b done=%b exp diff=9 bout=1 done=0", i, diff, borrow_out, done);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
